display_buffer_controller: RTL and testbench

- Sole owner of the character display buffer write port; shares it between CPU display-instruction writes and a hardware screen-clear sweep.
- CPU writes arrive from the display instruction dispatcher and are queued in a small FIFO.
- A clear request sweeps every cell with a blank character; CPU writes that arrive during a sweep are held and applied afterwards, in program order.

---
 rtl/display_buffer_controller.sv | 119 +++++++++++
 tb/tb_display_buffer_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/display_buffer_controller.sv
// Display buffer write-port owner: queues CPU writes in a small FIFO
// and interleaves them with a full-screen blank sweep.
module display_buffer_controller #(
  parameter int         POSITIONS  = 2400,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [6:0] BLANK_CHAR = 7'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_write_enable,
  input  logic [11:0] cpu_position,
  input  logic [6:0]  cpu_char_code,
  input  logic        clear_request,
  output logic        busy,
  output logic        fifo_full,
  output logic        dropped,
  output logic        buf_write_enable,
  output logic [11:0] buf_position,
  output logic [6:0]  buf_char_code
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_nx;
  logic [11:0]   counter;
  logic [18:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nx;
  logic          pos_ok, full, pop, push, sweep, sweep_done;
  logic          we_nx;
  logic [11:0]   pos_nx;
  logic [6:0]    ch_nx;

  assign pos_ok     = {20'd0, cpu_position} < 32'(POSITIONS);
  assign full       = count == CW'(FIFO_DEPTH);
  assign sweep_done = counter == 12'(POSITIONS - 1);
  assign sweep      = (state == CLEAR) && !clear_request;
  assign pop        = (state == IDLE) && !clear_request && (count != '0);
  // A write on the clear edge counts as newer than the clear, so it
  // always finds room in the freshly flushed queue.
  assign push       = cpu_write_enable && pos_ok
                      && (!full || pop || clear_request);
  assign count_nx   = clear_request ? CW'(push)
                      : count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
    end else begin
      if (clear_request) rd_ptr <= wr_ptr;
      else if (pop)      rd_ptr <= rd_ptr + AW'(1);
      if (push)          wr_ptr <= wr_ptr + AW'(1);
      count     <= count_nx;
      fifo_full <= count_nx == CW'(FIFO_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_position, cpu_char_code};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              counter <= '0;
    else if (clear_request)  counter <= '0;
    else if (state == CLEAR) counter <= sweep_done ? '0 : counter + 12'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear_request)                 state_nx = CLEAR;
    else if (state == CLEAR && sweep_done) state_nx = IDLE;
  end

  always_comb begin
    we_nx  = 1'b0;
    pos_nx = '0;
    ch_nx  = '0;
    unique case (1'b1)
      sweep: begin
        we_nx  = 1'b1;
        pos_nx = counter;
        ch_nx  = BLANK_CHAR;
      end
      pop: begin
        we_nx           = 1'b1;
        {pos_nx, ch_nx} = mem[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy             <= 1'b0;
      dropped          <= 1'b0;
      buf_write_enable <= 1'b0;
      buf_position     <= '0;
      buf_char_code    <= '0;
    end else begin
      busy             <= state_nx == CLEAR;
      dropped          <= cpu_write_enable && !push;
      buf_write_enable <= we_nx;
      buf_position     <= pos_nx;
      buf_char_code    <= ch_nx;
    end
  end

endmodule

// File: tb/tb_display_buffer_controller.sv
// Scoreboard bench for display_buffer_controller: directed stimulus
// pushes expected buffer writes, a negedge monitor pops and compares.
module tb_display_buffer_controller;

  localparam int POS = 2400;

  typedef struct packed {
    logic [11:0] pos;
    logic [6:0]  ch;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_write_enable = 1'b0;
  logic [11:0] cpu_position = '0;
  logic [6:0]  cpu_char_code = '0;
  logic        clear_request = 1'b0;
  logic        busy, fifo_full, dropped;
  logic        buf_write_enable;
  logic [11:0] buf_position;
  logic [6:0]  buf_char_code;

  wr_t sb[$];
  wr_t e;
  int  vectors = 0;
  int  miscompares = 0;
  int  exp_drops = 0;
  int  seen_drops = 0;

  display_buffer_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_write_enable (cpu_write_enable),
    .cpu_position     (cpu_position),
    .cpu_char_code    (cpu_char_code),
    .clear_request    (clear_request),
    .busy             (busy),
    .fifo_full        (fifo_full),
    .dropped          (dropped),
    .buf_write_enable (buf_write_enable),
    .buf_position     (buf_position),
    .buf_char_code    (buf_char_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dropped) seen_drops++;
      vectors++;
      if (buf_write_enable) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write got pos=%0d ch=%h, none expected",
                   buf_position, buf_char_code);
        end else begin
          e = sb.pop_front();
          if (e != {buf_position, buf_char_code}) begin
            miscompares++;
            $display("FAIL buf_write got pos=%0d ch=%h expected pos=%0d ch=%h",
                     buf_position, buf_char_code, e.pos, e.ch);
          end
        end
      end else if (buf_position != '0 || buf_char_code != '0) begin
        miscompares++;
        $display("FAIL idle_zero got pos=%0d ch=%h expected 0/0",
                 buf_position, buf_char_code);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic cpu(input logic [11:0] p, input logic [6:0] c);
    cpu_write_enable = 1'b1;
    cpu_position     = p;
    cpu_char_code    = c;
  endtask

  task automatic cpu_off();
    cpu_write_enable = 1'b0;
    cpu_position     = '0;
    cpu_char_code    = '0;
  endtask

  task automatic push_blanks(input int n);
    for (int i = 0; i < n; i++) sb.push_back({12'(i), 7'h20});
  endtask

  initial begin
    // reset state
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_we", buf_write_enable, 0);
    chk("rst_pos", buf_position, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // single write: sampled at edge 1, visible after edge 2 only
    cpu(12'd5, 7'h41);
    sb.push_back({12'd5, 7'h41});
    step();
    cpu_off();
    chk("single_lat1_we", buf_write_enable, 0);
    step();
    chk("single_we", buf_write_enable, 1);
    chk("single_pos", buf_position, 5);
    chk("single_ch", buf_char_code, 'h41);
    step();
    chk("single_after_we", buf_write_enable, 0);
    repeat (2) step();

    // back-to-back burst of six
    for (int i = 0; i < 6; i++) begin
      cpu(12'(i), 7'(8'h30 + i));
      sb.push_back({12'(i), 7'(8'h30 + i)});
      step();
      chk("burst_no_drop", dropped, 0);
    end
    cpu_off();
    repeat (8) step();

    // out-of-range position
    cpu(12'd2400, 7'h41);
    step();
    cpu_off();
    exp_drops++;
    chk("badpos_drop", dropped, 1);
    step();
    chk("badpos_drop_end", dropped, 0);
    chk("badpos_we", buf_write_enable, 0);
    repeat (3) step();

    // full sweep with six CPU writes arriving during it
    clear_request = 1'b1;
    push_blanks(POS);
    step();
    clear_request = 1'b0;
    chk("sweep_busy_on", busy, 1);
    for (int i = 0; i < 6; i++) begin
      cpu(12'(100 + i), 7'(8'h50 + i));
      if (i < 4) sb.push_back({12'(100 + i), 7'(8'h50 + i)});
      else       exp_drops++;
      step();
      chk("sweep_drop", dropped, (i >= 4) ? 1 : 0);
      if (i == 3) chk("sweep_full", fifo_full, 1);
    end
    cpu_off();
    repeat (POS - 7) step();
    chk("sweep_busy_last", busy, 1);
    step();
    chk("sweep_busy_off", busy, 0);
    chk("sweep_last_we", buf_write_enable, 1);
    chk("sweep_last_pos", buf_position, POS - 1);
    chk("sweep_full_held", fifo_full, 1);
    step();
    chk("drain_first_we", buf_write_enable, 1);
    chk("drain_first_pos", buf_position, 100);
    chk("drain_full_off", fifo_full, 0);
    repeat (6) step();

    // restart flushes older queued writes, keeps same-edge write
    clear_request = 1'b1;
    push_blanks(2);
    step();
    clear_request = 1'b0;
    cpu(12'd40, 7'h61);
    step();
    cpu(12'd41, 7'h62);
    step();
    clear_request = 1'b1;
    cpu(12'd7, 7'h5A);
    push_blanks(POS);
    sb.push_back({12'd7, 7'h5A});
    step();
    clear_request = 1'b0;
    cpu_off();
    chk("flush_count_one", fifo_full, 0);
    repeat (POS + 6) step();
    chk("flush_sb_drained", sb.size(), 0);

    // asynchronous reset mid-sweep
    clear_request = 1'b1;
    push_blanks(POS);
    step();
    clear_request = 1'b0;
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_busy", busy, 0);
    chk("arst_we", buf_write_enable, 0);
    chk("arst_pos", buf_position, 0);
    step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("arst_no_resume", busy, 0);

    chk("drop_count", seen_drops, exp_drops);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
